// File: rtl/prog_loader_if.sv
// Program loader bus: upstream beat stream plus the two memory write ports.
// The loader takes the slave side; the stream source / memories take the master side.
interface prog_loader_if;
    logic        s_valid;
    logic [63:0] s_data;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;

    modport slave (
        input  s_valid, s_data,
        output s_ready,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport master (
        output s_valid, s_data,
        input  s_ready,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface

// File: rtl/prog_loader.sv
// Streams an instruction image then a data image into the CPU memories,
// then holds the CPU enabled until abort or reset.
module prog_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [9:0]    n_instr,
    input  logic [10:0]   n_data,
    prog_loader_if.slave  bus,
    output logic          enable,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, LOAD_I, LOAD_D, RUN} state_t;

    localparam logic [10:0] IMAX = 11'(IMEM_WORDS);
    localparam logic [11:0] DMAX = 12'(DMEM_WORDS);

    state_t      state_q, state_d;
    logic [10:0] idx_q, idx_d;
    logic [9:0]  ni_q, ni_d;
    logic [10:0] nd_q, nd_d;
    logic        s_ready_q, s_ready_d;
    logic        enable_q, enable_d;
    logic        err_q, err_d;
    logic        wen_q, wen_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen2_q, wen2_d;
    logic [63:0] addr2_q, addr2_d;
    logic [63:0] wdata2_q, wdata2_d;

    logic accept;
    logic illegal;
    logic last_i;
    logic last_d;

    assign accept  = bus.s_valid && s_ready_q;
    assign illegal = (n_instr == '0) ||
                     ({1'b0, n_instr} > IMAX) ||
                     ({1'b0, n_data} > DMAX);
    assign last_i  = idx_q == ({1'b0, ni_q} - 11'd1);
    assign last_d  = idx_q == (nd_q - 11'd1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ni_d     = ni_q;
        nd_d     = nd_q;
        err_d    = 1'b0;
        wen_d    = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen2_d   = 1'b0;
        addr2_d  = addr2_q;
        wdata2_d = wdata2_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        ni_d    = n_instr;
                        nd_d    = n_data;
                        idx_d   = '0;
                        state_d = LOAD_I;
                    end
                end
            end
            LOAD_I: begin
                if (accept) begin
                    wen_d   = 1'b1;
                    addr_d  = 64'({idx_q, 2'b00});
                    wdata_d = bus.s_data[31:0];
                    if (last_i) begin
                        idx_d   = '0;
                        state_d = (nd_q != '0) ? LOAD_D : RUN;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
            end
            LOAD_D: begin
                if (accept) begin
                    wen2_d   = 1'b1;
                    addr2_d  = 64'({idx_q, 3'b000});
                    wdata2_d = bus.s_data;
                    if (last_d) begin
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
            end
            RUN: begin
            end
            default: state_d = IDLE;
        endcase
        // abort beats everything, including a strobe that would issue next cycle
        if (abort) begin
            state_d = IDLE;
            err_d   = 1'b0;
            wen_d   = 1'b0;
            wen2_d  = 1'b0;
        end
        s_ready_d = (state_d == LOAD_I) || (state_d == LOAD_D);
        enable_d  = (state_q == RUN) && !abort;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ni_q      <= '0;
            nd_q      <= '0;
            s_ready_q <= 1'b0;
            enable_q  <= 1'b0;
            err_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen2_q    <= 1'b0;
            addr2_q   <= '0;
            wdata2_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ni_q      <= ni_d;
            nd_q      <= nd_d;
            s_ready_q <= s_ready_d;
            enable_q  <= enable_d;
            err_q     <= err_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen2_q    <= wen2_d;
            addr2_q   <= addr2_d;
            wdata2_q  <= wdata2_d;
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.wen_ext     = wen_q;
    assign bus.ren_ext     = 1'b0;
    assign bus.addr_ext    = addr_q;
    assign bus.wdata_ext   = wdata_q;
    assign bus.wen_ext_2   = wen2_q;
    assign bus.ren_ext_2   = 1'b0;
    assign bus.addr_ext_2  = addr2_q;
    assign bus.wdata_ext_2 = wdata2_q;
    assign enable          = enable_q;
    assign err             = err_q;
    assign busy            = (state_q == LOAD_I) || (state_q == LOAD_D);

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 512, meaning the instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 1024, meaning the data memory depth in 64-bit words.
REQ-003 SHALL have one clock and an asynchronous active-low reset; ports clk and arst_n.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 arst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-007 abort  input  1  return to IDLE from any state.
REQ-008 n_instr  input  10  number of instruction words to load; legal range 1..IMEM_WORDS.
REQ-009 n_data  input  11  number of data words to load; legal range 0..DMEM_WORDS.
REQ-010 s_valid  input  1  the upstream stream beat is valid.
REQ-011 s_data  input  64  stream beat; instruction phase uses [31:0], data phase uses [63:0].
REQ-012 s_ready  output  1  the loader accepts a beat this cycle.
REQ-013 addr_ext, wen_ext, ren_ext, wdata_ext  output  64/1/1/32  instruction memory external write port.
REQ-014 addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  output  64/1/1/64  data memory external write port.
REQ-015 enable  output  1  CPU run enable.
REQ-016 busy  output  1  high in LOAD_I or LOAD_D.
REQ-017 err  output  1  one-cycle pulse on an illegal start.

Function
REQ-018 SHALL implement the states IDLE, LOAD_I, LOAD_D and RUN.
REQ-019 IDLE + start with legal counts: SHALL latch n_instr and n_data, clear the beat index and move to LOAD_I.
REQ-020 IDLE + start with n_instr==0, n_instr>IMEM_WORDS or n_data>DMEM_WORDS: SHALL pulse err the next cycle and stay in IDLE.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 s_ready SHALL be a registered signal that is high exactly while the state is LOAD_I or LOAD_D.
REQ-023 A beat SHALL transfer in any cycle where s_valid&&s_ready; s_valid low SHALL stall without loss; a beat SHALL never be accepted twice.
REQ-024 A beat accepted in LOAD_I at cycle T SHALL produce, in cycle T+1 only, wen_ext=1, addr_ext=idx*4 (zero-extended to 64 bits) and wdata_ext=s_data[31:0].
REQ-025 A beat accepted in LOAD_D at cycle T SHALL produce, in cycle T+1 only, wen_ext_2=1, addr_ext_2=idx*8 and wdata_ext_2=s_data.
REQ-026 idx SHALL count from 0, increment per accepted beat and reset to 0 on entry to LOAD_D.
REQ-027 After the beat with idx==n_instr-1 in LOAD_I, the next state SHALL be LOAD_D if n_data>0, else RUN.
REQ-028 After the beat with idx==n_data-1 in LOAD_D, the next state SHALL be RUN.
REQ-029 The state SHALL update on the edge that ends the final-beat cycle; enable SHALL register state==RUN, so enable first rises one cycle after the final write strobe.
REQ-030 ren_ext and ren_ext_2 SHALL be held at 0; write strobes SHALL never be asserted outside the cycle after an accepted beat.
REQ-031 abort in any state SHALL force IDLE on the next edge, deassert enable and s_ready, and drop any strobe not yet issued.
REQ-032 A final strobe already scheduled at the abort edge SHALL be suppressed.
REQ-033 If abort and start are high in the same cycle, abort SHALL win.
REQ-034 RUN SHALL persist, with enable=1, until abort or reset.

Reset
REQ-035 On arst_n low, the block SHALL immediately enter IDLE, independent of clk.
REQ-036 During reset, every output SHALL be 0 (s_ready, all strobes, all addresses and data, enable, busy, err).
REQ-037 Reset mid-load SHALL discard progress; a fresh start SHALL be required after reset release.

Verification
REQ-038 start, n_instr=3, n_data=0, 3 beats with s_valid held -> wen_ext pulses at addr 0, 4, 8; enable rises one cycle after the third pulse; wen_ext_2 never toggles.
REQ-039 n_instr=2, n_data=2, data beats 0xDEADBEEF_00000001 and 0x2 -> wen_ext_2 pulses at addr 0 then 8 with matching data; then enable=1.
REQ-040 s_valid toggled 1,0,0,1 during LOAD_I -> exactly 2 writes, at addr 0 and 4; no duplicate strobe.
REQ-041 start with n_instr=0, then n_instr=513, then n_data=1025 -> err pulses each time; state stays IDLE; s_ready stays 0.
REQ-042 abort after 1 of 4 instruction beats -> next cycle s_ready=0, busy=0, no further strobes; enable=0.
REQ-043 arst_n low mid-LOAD_D -> all outputs 0 asynchronously; after release, start with n_instr=1 loads from addr 0.
